// File: rtl/vm2413_pkg.sv
// ---------------------------------------------------------------------------
// vm2413 -- shared types, constants and helpers for the VM2413 FM core.
//
// Contents:
//   SLOT_TYPE       5-bit slot index (0..17); slot[0]=1 marks a carrier.
//   STAGE_TYPE      2-bit stage index within a slot (0..3).
//   SIGNED_LI_TYPE  sign-magnitude operator output (sign + 9-bit magnitude).
//   MIX_W           width of the channel mixer accumulators and outputs.
//   BD_CAR/HH/SD/TOM/CYM  slots that carry the rhythm instruments.
//   sm_to_tc()      sign-magnitude to two's-complement conversion.
//   slot_route()    which mixer accumulator a slot feeds in a given mode.
// ---------------------------------------------------------------------------
package vm2413;

    localparam int MIX_W  = 14;
    localparam int SLOT_N = 18;

    typedef logic [4:0] SLOT_TYPE;
    typedef logic [1:0] STAGE_TYPE;

    typedef struct packed {
        logic       sign;
        logic [8:0] value;
    } SIGNED_LI_TYPE;

    localparam SLOT_TYPE BD_CAR    = 5'd13;
    localparam SLOT_TYPE HH        = 5'd14;
    localparam SLOT_TYPE SD        = 5'd15;
    localparam SLOT_TYPE TOM       = 5'd16;
    localparam SLOT_TYPE CYM       = 5'd17;
    localparam SLOT_TYPE LAST_SLOT = 5'd17;
    // Highest slot that still belongs to a melody channel in rhythm mode.
    localparam SLOT_TYPE LAST_MEL_RHY = 5'd11;

    typedef enum logic [1:0] {
        ROUTE_NONE,
        ROUTE_MEL,
        ROUTE_RHY
    } route_e;

    // Negative zero collapses to zero naturally since -0 == 0.
    function automatic logic signed [MIX_W-1:0] sm_to_tc(input SIGNED_LI_TYPE d);
        logic signed [MIX_W-1:0] mag;
        mag = signed'({{(MIX_W-9){1'b0}}, d.value});
        return d.sign ? -mag : mag;
    endfunction

    function automatic route_e slot_route(input SLOT_TYPE s, input logic rhy_mode);
        logic is_rhy_slot;
        is_rhy_slot = (s == BD_CAR) || (s == HH) || (s == SD) || (s == TOM) || (s == CYM);
        if (rhy_mode && is_rhy_slot)
            return ROUTE_RHY;
        // In rhythm mode slot 12 (BD modulator) is excluded by the <= 11 bound.
        if (s[0] && (s <= LAST_SLOT) && (!rhy_mode || (s <= LAST_MEL_RHY)))
            return ROUTE_MEL;
        return ROUTE_NONE;
    endfunction

endpackage

// File: rtl/slot_mixer.sv
// ---------------------------------------------------------------------------
// slot_mixer -- per-frame melody / rhythm mixer for the VM2413 slot pipeline.
//
// Walks the 18-slot x 4-stage frame alongside the operator pipeline, reads
// each slot's output from the operator memory, converts it to two's
// complement and sums carriers into a melody and a rhythm accumulator. At
// the end of each complete frame the sums are published and frame_vld
// pulses for one cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   clkena     in   advance enable; nothing changes while low
//   slot       in   current slot (0..17)
//   stage      in   current stage (0..3)
//   rhythm     in   rhythm-mode flag, latched at slot 0 / stage 0
//   maddr      out  read address to the operator memory (1-cycle latency)
//   mdata      in   sign-magnitude slot output read back from maddr
//   melody     out  signed melody sum of the last complete frame
//   rhy        out  signed rhythm sum of the last complete frame
//   frame_vld  out  one-cycle pulse when melody/rhy update
//
// Build option:
//   SLOT_MIXER_SAT_EN  when defined, melody/rhy are clamped to -2048..+2047
//                      at transfer; otherwise the full 14-bit sums pass.
// ---------------------------------------------------------------------------
module slot_mixer
    import vm2413::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clkena,
    input  SLOT_TYPE                slot,
    input  STAGE_TYPE               stage,
    input  logic                    rhythm,
    output SLOT_TYPE                maddr,
    input  SIGNED_LI_TYPE           mdata,
    output logic signed [MIX_W-1:0] melody,
    output logic signed [MIX_W-1:0] rhy,
    output logic                    frame_vld
);

    SLOT_TYPE                r_maddr;
    logic signed [MIX_W-1:0] r_mel_acc;
    logic signed [MIX_W-1:0] r_rhy_acc;
    logic signed [MIX_W-1:0] r_melody;
    logic signed [MIX_W-1:0] r_rhy;
    logic                    r_frame_vld;
    logic                    r_rhy_lat;
    logic                    r_armed;

    logic                    w_frame_start;
    logic                    w_sample;
    logic                    w_transfer;
    logic signed [MIX_W-1:0] w_term;
    route_e                  w_route;
    logic signed [MIX_W-1:0] w_mel_nxt;
    logic signed [MIX_W-1:0] w_rhy_nxt;
    logic signed [MIX_W-1:0] w_mel_out;
    logic signed [MIX_W-1:0] w_rhy_out;

    assign w_frame_start = clkena && (slot == 5'd0) && (stage == 2'd0);
    assign w_sample      = clkena && (stage == 2'd2);
    // Only a frame that began while armed may publish; a frame cut short by
    // reset reaches slot 17 unarmed and is dropped.
    assign w_transfer    = clkena && r_armed && (slot == LAST_SLOT) && (stage == 2'd3);

    assign w_term  = sm_to_tc(mdata);
    // Slot 0 / stage 0 and the sample at slot 0 / stage 2 are separate edges,
    // so r_rhy_lat already holds this frame's mode whenever a sample happens.
    assign w_route = slot_route(slot, r_rhy_lat);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_mel_nxt = r_mel_acc;
        w_rhy_nxt = r_rhy_acc;
        if (w_sample) begin
            if (slot == 5'd0) begin
                // Slot 0 is never a contributor: load the frame's first term (0).
                w_mel_nxt = '0;
                w_rhy_nxt = '0;
            end else begin
                case (w_route)
                    ROUTE_MEL: w_mel_nxt = r_mel_acc + w_term;
                    ROUTE_RHY: w_rhy_nxt = r_rhy_acc + w_term;
                    default:   ;
                endcase
            end
        end
    end

`ifdef SLOT_MIXER_SAT_EN
    function automatic logic signed [MIX_W-1:0] sat12(input logic signed [MIX_W-1:0] v);
        if (v > 14'sd2047)
            return 14'sd2047;
        if (v < -14'sd2048)
            return -14'sd2048;
        return v;
    endfunction

    assign w_mel_out = sat12(r_mel_acc);
    assign w_rhy_out = sat12(r_rhy_acc);
`else
    assign w_mel_out = r_mel_acc;
    assign w_rhy_out = r_rhy_acc;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_maddr     <= '0;
            r_mel_acc   <= '0;
            r_rhy_acc   <= '0;
            r_melody    <= '0;
            r_rhy       <= '0;
            r_frame_vld <= 1'b0;
            r_rhy_lat   <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            // frame_vld is a pure one-cycle pulse; it drops on the next edge
            // whether or not clkena is high there.
            r_frame_vld <= w_transfer;

            if (clkena && (stage == 2'd0))
                r_maddr <= slot;

            if (w_frame_start) begin
                r_rhy_lat <= rhythm;
                r_armed   <= 1'b1;
            end

            r_mel_acc <= w_mel_nxt;
            r_rhy_acc <= w_rhy_nxt;

            // Slot 17's term was added at stage 2, so the accumulators are
            // complete by stage 3.
            if (w_transfer) begin
                r_melody <= w_mel_out;
                r_rhy    <= w_rhy_out;
            end
        end
    end

    assign maddr     = r_maddr;
    assign melody    = r_melody;
    assign rhy       = r_rhy;
    assign frame_vld = r_frame_vld;

endmodule

// File: tb/tb_slot_mixer.sv
// ---------------------------------------------------------------------------
// tb_slot_mixer -- self-checking bench for slot_mixer.
//
// Drives the slot/stage sequence frame by frame, backs maddr/mdata with a
// small registered memory, and predicts melody/rhy per frame from the mixing
// rules using plain integer sums over the memory contents.
// ---------------------------------------------------------------------------
module tb_slot_mixer;
    import vm2413::*;

    logic                    clk     = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    clkena  = 1'b0;
    logic                    rhythm  = 1'b0;
    SLOT_TYPE                slot    = '0;
    STAGE_TYPE               stage   = '0;
    SLOT_TYPE                maddr;
    SIGNED_LI_TYPE           mdata;
    logic signed [MIX_W-1:0] melody;
    logic signed [MIX_W-1:0] rhy;
    logic                    frame_vld;

    SIGNED_LI_TYPE mem [32];

    int     n_vec    = 0;
    int     n_bad    = 0;
    int     vld_cnt  = 0;
    longint clk_cnt  = 0;
    longint last_vld = -1;
    longint prev_vld = -1;
    int     hold_mel = 0;
    int     hold_rhy = 0;

    slot_mixer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clkena    (clkena),
        .slot      (slot),
        .stage     (stage),
        .rhythm    (rhythm),
        .maddr     (maddr),
        .mdata     (mdata),
        .melody    (melody),
        .rhy       (rhy),
        .frame_vld (frame_vld)
    );

    always #5 clk = ~clk;

    // Operator output memory: one-cycle read latency from maddr.
    always @(posedge clk) mdata <= mem[maddr];

    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    always @(negedge clk) begin
        if (frame_vld === 1'b1) begin
            vld_cnt  = vld_cnt + 1;
            prev_vld = last_vld;
            last_vld = clk_cnt;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the frame's sums from the mixing rules and the memory image.
    function automatic void model(input bit rh, output int mel, output int rr);
        mel = 0;
        rr  = 0;
        for (int s = 0; s < SLOT_N; s++) begin
            int v;
            v = int'(mem[s].value);
            if (mem[s].sign) v = -v;
            if (rh && s >= 13)
                rr += v;
            else if ((s % 2 == 1) && (!rh || s <= 11))
                mel += v;
        end
`ifdef SLOT_MIXER_SAT_EN
        if (mel > 2047) mel = 2047;
        if (mel < -2048) mel = -2048;
        if (rr > 2047) rr = 2047;
        if (rr < -2048) rr = -2048;
`endif
    endfunction

    task automatic step(input bit e, input int s, input int st, input bit rh);
        slot   = SLOT_TYPE'(s);
        stage  = STAGE_TYPE'(st);
        rhythm = rh;
        clkena = e;
        @(posedge clk);
        #1;
        clkena = 1'b0;
    endtask

    // idle_mode: 0 = clkena always high, 1 = low/high alternating,
    // 2 = random 0..2 low cycles before each high one.
    // rst_slot >= 0 pulses reset_n after stage 1 of that slot.
    task automatic drive_frame(input string tag, input bit rh0, input bit rh1,
                               input int tog_slot, input int idle_mode,
                               input int rst_slot, input bit exp_upd);
        int c0;
        int em;
        int er;
        c0 = vld_cnt;
        model(rh0, em, er);
        for (int s = 0; s < SLOT_N; s++) begin
            for (int st = 0; st < 4; st++) begin
                bit rh;
                int idles;
                rh    = (s >= tog_slot) ? rh1 : rh0;
                idles = (idle_mode == 1) ? 1 : (idle_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (idles) step(1'b0, s, st, rh);
                step(1'b1, s, st, rh);
                if (st == 0) check({tag, "_maddr"}, maddr, s);
                if (s == rst_slot && st == 1) begin
                    #1 reset_n = 1'b0;
                    #1;
                    check({tag, "_rst_maddr"}, maddr, 0);
                    check({tag, "_rst_melody"}, melody, 0);
                    check({tag, "_rst_rhy"}, rhy, 0);
                    check({tag, "_rst_vld"}, frame_vld, 0);
                    @(negedge clk);
                    #1 reset_n = 1'b1;
                    hold_mel = 0;
                    hold_rhy = 0;
                end
            end
        end
        @(negedge clk);
        if (exp_upd) begin
            hold_mel = em;
            hold_rhy = er;
        end
        check({tag, "_vld"}, frame_vld, exp_upd);
        check({tag, "_melody"}, melody, hold_mel);
        check({tag, "_rhy"}, rhy, hold_rhy);
        #1;
        check({tag, "_vld_count"}, vld_cnt - c0, exp_upd ? 1 : 0);
    endtask

    task automatic rand_mem();
        for (int s = 0; s < SLOT_N; s++) begin
            mem[s].sign  = 1'($urandom);
            mem[s].value = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_maddr", maddr, 0);
        check("reset_melody", melody, 0);
        check("reset_rhy", rhy, 0);
        check("reset_vld", frame_vld, 0);
        #1 reset_n = 1'b1;

        // Melody mode: carriers +100, modulators +511.
        for (int s = 0; s < SLOT_N; s++) mem[s] = (s % 2 == 1) ? {1'b0, 9'd100} : {1'b0, 9'd511};
        drive_frame("melody100", 1'b0, 1'b0, 99, 0, -1, 1'b1);

        // Rhythm mode: odd 1..11 at -50, slot 12 at +300, 13..17 at +511.
        rand_mem();
        for (int s = 1; s <= 11; s += 2) mem[s] = {1'b1, 9'd50};
        mem[12] = {1'b0, 9'd300};
        for (int s = 13; s <= 17; s++) mem[s] = {1'b0, 9'd511};
        drive_frame("rhythm", 1'b1, 1'b1, 99, 0, -1, 1'b1);

        // Rhythm raised mid-frame: this frame stays melody, next is rhythm.
        rand_mem();
        drive_frame("toggle_cur", 1'b0, 1'b1, 9, 0, -1, 1'b1);
        rand_mem();
        drive_frame("toggle_next", 1'b1, 1'b1, 99, 0, -1, 1'b1);

        // Reset at slot 8 discards the partial frame.
        rand_mem();
        for (int s = 1; s < SLOT_N; s += 2) mem[s] = {1'b0, 9'd511};
        drive_frame("rst_partial", 1'b0, 1'b0, 99, 0, 8, 1'b0);
        drive_frame("rst_full", 1'b0, 1'b0, 99, 0, -1, 1'b1);

        // Negative-zero carriers with clkena alternating: 144-clock frames.
        rand_mem();
        for (int s = 1; s < SLOT_N; s += 2) mem[s] = {1'b1, 9'd0};
        drive_frame("negzero_a", 1'b0, 1'b0, 99, 1, -1, 1'b1);
        drive_frame("negzero_b", 1'b0, 1'b0, 99, 1, -1, 1'b1);
        check("frame_period", int'(last_vld - prev_vld), 144);

        // Random contents, modes, mid-frame toggles and clkena gaps.
        for (int f = 0; f < 8; f++) begin
            int tog;
            rand_mem();
            tog = ($urandom_range(0, 1) == 0) ? 99 : int'($urandom_range(1, 17));
            drive_frame($sformatf("rand%0d", f), 1'($urandom), 1'($urandom), tog, 2, -1, 1'b1);
        end

        step(1'b0, 0, 0, 1'b0);
        @(negedge clk);
        check("vld_idle", frame_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
